// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and sizing helper for the COREFIFO write-port arbiter.
// Imported by the round-robin selector and the arbiter top.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int DEF_NREQ      = 4;
   localparam int DEF_WIDTH     = 16;
   localparam int DEF_MAX_BURST = 8;
   localparam int DEF_CNTW      = 16;

   // Ceiling log2, never below one bit so single-value counters stay legal.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = 1;
      for (int b = 1; b < 31; b++) begin
         if ((1 << b) < value) bits = b + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after i_ptr, wrapping modulo NREQ.
// Works for any NREQ, including non-powers of two.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = clog2_min1(DEF_NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_onehot,
   output logic [PW-1:0]   o_idx,
   output logic            o_any
);

   logic [PW-1:0] w_cand;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = PW'((int'(i_ptr) + k) % NREQ);
         if (!o_any && i_req[w_cand]) begin
            o_any            = 1'b1;
            o_idx            = w_cand;
            o_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of one COREFIFO write port among NREQ requesters.
// Also provides a global enable, a registered grant and a saturating accepted-word counter.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CNTW      = DEF_CNTW
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  EN,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*WIDTH-1:0] REQ_DATA,
   output logic [NREQ-1:0]       ACK,
   output logic [NREQ-1:0]       GNT,
   input  logic                  FIFO_FULL,
   output logic                  FIFO_WE,
   output logic [WIDTH-1:0]      FIFO_DATA,
   output logic                  BUSY,
   output logic [CNTW-1:0]       WORD_CNT,
   output state_t                DBG_STATE
);

   localparam int PW = clog2_min1(NREQ);
   localparam int BW = clog2_min1(MAX_BURST);
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

   state_t           r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [PW-1:0]    r_gidx;
   logic [PW-1:0]    r_rr_ptr;
   logic [BW-1:0]    r_burst_cnt;
   logic [CNTW-1:0]  r_word_cnt;
   logic             r_busy;

   logic [NREQ-1:0]  w_pick_onehot;
   logic [PW-1:0]    w_pick_idx;
   logic             w_pick_any;
   logic             w_req_g;
   logic             w_accept;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
      .i_req    (REQ),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   // Handshake: REQ[i] is a valid flag held with its data until ACK[i]; ACK/FIFO_WE is the
   // same-cycle ready, asserted only for the granted requester while the FIFO is not full.
   assign w_req_g   = REQ[r_gidx];
   assign w_accept  = RESET_N & (r_state == BURST) & w_req_g & ~FIFO_FULL;
   assign ACK       = w_accept ? r_gnt : '0;
   assign FIFO_WE   = w_accept;
   assign FIFO_DATA = w_accept ? REQ_DATA[r_gidx*WIDTH +: WIDTH] : '0;

   assign GNT       = r_gnt;
   assign BUSY      = r_busy;
   assign WORD_CNT  = r_word_cnt;
   assign DBG_STATE = r_state;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_gidx      <= '0;
         r_busy      <= 1'b0;
         r_burst_cnt <= '0;
         r_rr_ptr    <= PW'(NREQ - 1);
         r_word_cnt  <= '0;
      end else begin
         if (w_accept && (r_word_cnt != {CNTW{1'b1}})) r_word_cnt <= r_word_cnt + 1'b1;
         case (r_state)
            IDLE: begin
               if (EN && w_pick_any) begin
                  r_state     <= BURST;
                  r_gnt       <= w_pick_onehot;
                  r_gidx      <= w_pick_idx;
                  r_busy      <= 1'b1;
                  r_burst_cnt <= '0;
               end
            end
            BURST: begin
               if (w_accept) r_burst_cnt <= r_burst_cnt + 1'b1;
               // A stall (FIFO full) never ends the burst; only the limit or a withdrawal does.
               if ((w_accept && (r_burst_cnt == LAST_BEAT)) || !w_req_g) begin
                  r_state  <= IDLE;
                  r_rr_ptr <= r_gidx;
                  r_gnt    <= '0;
                  r_busy   <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios then randomized traffic against
// a cycle-level behavioural model of grant/burst rules kept in the bench.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int MAXB  = 8;
   localparam int CNTW  = 8;

   logic                  CLK = 1'b0;
   logic                  RESET_N;
   logic                  EN;
   logic [NREQ-1:0]       REQ;
   logic [NREQ*WIDTH-1:0] REQ_DATA;
   logic [NREQ-1:0]       ACK;
   logic [NREQ-1:0]       GNT;
   logic                  FIFO_FULL;
   logic                  FIFO_WE;
   logic [WIDTH-1:0]      FIFO_DATA;
   logic                  BUSY;
   logic [CNTW-1:0]       WORD_CNT;
   state_t                DBG_STATE;

   fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAXB), .CNTW(CNTW)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .REQ(REQ), .REQ_DATA(REQ_DATA),
      .ACK(ACK), .GNT(GNT), .FIFO_FULL(FIFO_FULL), .FIFO_WE(FIFO_WE),
      .FIFO_DATA(FIFO_DATA), .BUSY(BUSY), .WORD_CNT(WORD_CNT), .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- bench state ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [WIDTH+NREQ:0] exp_q[$];

   int               rem[NREQ];
   logic [WIDTH-1:0] word[NREQ];
   logic [NREQ-1:0]  req_r;
   int p_raise = 100, p_drop = 0, p_full = 0;
   bit en_v = 1'b1, rst_v = 1'b0, full_stall = 1'b0;

   bit m_busy;
   int m_owner, m_cnt, m_ptr, m_words, m_last_acc, m_bcyc;

   bit              chk_en = 1'b0;
   logic [NREQ-1:0] exp_gnt;
   bit              exp_busy, exp_we;
   int              exp_wc;

   logic [NREQ-1:0] prev_gnt = '0;
   logic [31:0]     gnt_code;
   int              gnt_n, wr_cnt, stall_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_log();
      gnt_code = 0; gnt_n = 0; wr_cnt = 0; stall_cnt = 0;
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_cnt = 0; m_ptr = NREQ - 1; m_words = 0; m_last_acc = -1;
      m_owner = 0; m_bcyc = 0;
   endtask

   // ---------------- driver + reference model (one call = one clock cycle) ----------------
   task automatic step();
      bit acc;
      @(posedge CLK);
      #1;
      if (m_last_acc >= 0) begin
         rem[m_last_acc]--;
         word[m_last_acc] = word[m_last_acc] + 16'h0001;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (m_busy && m_owner == i)
            req_r[i] = (rem[i] > 0) && ($urandom_range(99) >= p_drop);
         else if (req_r[i])
            req_r[i] = (rem[i] > 0);
         else
            req_r[i] = (rem[i] > 0) && ($urandom_range(99) < p_raise);
      end
      REQ     = req_r;
      for (int i = 0; i < NREQ; i++) REQ_DATA[i*WIDTH +: WIDTH] = word[i];
      EN      = en_v;
      RESET_N = rst_v;
      if (full_stall) FIFO_FULL = m_busy && (m_bcyc >= 2) && (m_bcyc <= 5);
      else            FIFO_FULL = ($urandom_range(99) < p_full);

      exp_gnt  = m_busy ? (NREQ'(1) << m_owner) : '0;
      exp_busy = m_busy;
      exp_wc   = m_words;
      acc      = rst_v && m_busy && REQ[m_owner] && !FIFO_FULL;
      exp_we   = acc;
      m_last_acc = acc ? m_owner : -1;
      if (acc) exp_q.push_back({1'b1, exp_gnt, word[m_owner]});

      if (!rst_v) begin
         model_reset();
      end else if (!m_busy) begin
         if (en_v && REQ != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (REQ[(m_ptr + k) % NREQ]) begin
                  m_owner = (m_ptr + k) % NREQ;
                  break;
               end
            end
            m_busy = 1'b1; m_cnt = 0; m_bcyc = 0;
         end
      end else begin
         m_bcyc++;
         if (acc) begin
            m_cnt++;
            if (m_words < (1 << CNTW) - 1) m_words++;
         end
         if (m_cnt == MAXB || !REQ[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = m_owner;
         end
      end
   endtask

   task automatic pulse_reset();
      rst_v = 1'b0;
      step();
      rst_v = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [WIDTH+NREQ:0] e;
      forever begin
         @(negedge CLK);
         if (chk_en) begin
            check("gnt", 64'(GNT), 64'(exp_gnt));
            check("busy", 64'(BUSY), 64'(exp_busy));
            check("state", 64'(DBG_STATE), 64'(exp_busy));
            check("word_cnt", 64'(WORD_CNT), 64'(exp_wc));
            check("we", 64'(FIFO_WE), 64'(exp_we));
            if (GNT != '0 && prev_gnt == '0) begin
               for (int i = 0; i < NREQ; i++) if (GNT[i]) gnt_code = (gnt_code << 4) | i;
               gnt_n++;
            end
            if (GNT != '0 && !FIFO_WE) stall_cnt++;
            prev_gnt = GNT;
            if (FIFO_WE || ACK != '0) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL write: unexpected write ack=%0h data=%0h", ACK, FIFO_DATA);
               end else begin
                  e = exp_q.pop_front();
                  check("write", 64'({FIFO_WE, ACK, FIFO_DATA}), 64'(e));
               end
            end else begin
               check("data_idle", 64'(FIFO_DATA), 64'(0));
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   initial begin
      RESET_N = 1'b0; EN = 1'b1; FIFO_FULL = 1'b0; REQ = '0; REQ_DATA = '0; req_r = '0;
      for (int i = 0; i < NREQ; i++) begin
         rem[i]  = 0;
         word[i] = 16'(16'h00A0 + i * 16'h1000);
      end
      model_reset();
      clear_log();
      chk_en = 1'b1;
      rst_v  = 1'b0;
      step();
      step();
      rst_v = 1'b1;

      // Single requester, one full burst of 8 from 0x00A0
      rem[0] = 8;
      repeat (14) step();
      check("p1_writes", 64'(wr_cnt), 64'(8));
      check("p1_word_cnt", 64'(WORD_CNT), 64'(8));
      check("p1_order", 64'({gnt_n, gnt_code}), 64'({32'd1, 32'h0}));

      // All four requesting after reset: 0,1,2,3,0
      pulse_reset();
      clear_log();
      rem[0] = 16; rem[1] = 8; rem[2] = 8; rem[3] = 8;
      repeat (52) step();
      check("p2_writes", 64'(wr_cnt), 64'(40));
      check("p2_word_cnt", 64'(WORD_CNT), 64'(40));
      check("p2_order", 64'({gnt_n, gnt_code}), 64'({32'd5, 32'h01230}));

      // Requester 2 stalled by FULL for burst cycles 3..6
      clear_log();
      full_stall = 1'b1;
      rem[2] = 8;
      repeat (20) step();
      full_stall = 1'b0;
      check("p3_writes", 64'(wr_cnt), 64'(8));
      check("p3_stall", 64'(stall_cnt), 64'(4));
      check("p3_order", 64'({gnt_n, gnt_code}), 64'({32'd1, 32'h2}));

      // Requester 1 withdraws after 3 words, then 1 and 2 contend
      clear_log();
      rem[1] = 3;
      repeat (10) step();
      check("p4_writes_a", 64'(wr_cnt), 64'(3));
      rem[1] = 4; rem[2] = 4;
      repeat (16) step();
      check("p4_writes", 64'(wr_cnt), 64'(11));
      check("p4_order", 64'({gnt_n, gnt_code}), 64'({32'd3, 32'h121}));
      check("p4_word_cnt", 64'(WORD_CNT), 64'(59));

      // EN low blocks grants; EN dropped mid-burst lets the burst finish
      clear_log();
      en_v = 1'b0;
      for (int i = 0; i < NREQ; i++) rem[i] = 8;
      repeat (10) step();
      check("p5_no_grant", 64'(gnt_n), 64'(0));
      en_v = 1'b1;
      step();
      en_v = 1'b0;
      repeat (20) step();
      check("p5_writes", 64'(wr_cnt), 64'(8));
      check("p5_order", 64'({gnt_n, gnt_code}), 64'({32'd1, 32'h2}));
      check("p5_word_cnt", 64'(WORD_CNT), 64'(67));

      // Reset after 5 words of a burst; requester 3 wins first afterwards
      en_v = 1'b1;
      for (int c = 0; c < 30 && !(m_busy && m_cnt == 5); c++) step();
      check("p6_reached", 64'(m_cnt), 64'(5));
      for (int i = 0; i < NREQ - 1; i++) rem[i] = 0;
      pulse_reset();
      clear_log();
      step();
      check("p6_word_cnt", 64'(WORD_CNT), 64'(0));
      repeat (12) step();
      check("p6_order", 64'({gnt_n, gnt_code}), 64'({32'd1, 32'h3}));

      // Randomized traffic with stalls, withdrawals, EN toggling and rare resets
      p_raise = 30; p_drop = 4; p_full = 20;
      for (int c = 0; c < 2000; c++) begin
         if (c % 40 == 0)
            for (int i = 0; i < NREQ; i++) if (rem[i] == 0) rem[i] = $urandom_range(20);
         en_v = ($urandom_range(99) < 90);
         if ($urandom_range(999) < 2) pulse_reset();
         else step();
      end

      // Drain
      p_full = 0; p_drop = 0; en_v = 1'b1;
      for (int i = 0; i < NREQ; i++) rem[i] = 0;
      repeat (20) step();
      check("queue_empty", 64'(exp_q.size()), 64'(0));

      @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one COREFIFO instance among NREQ requesters using round-robin, burst-limited grants.
- Sits on the WCLK side in front of the FIFO: requesters present data plus a request, and the arbiter drives FIFO WE/DATA while honouring FULL.
- Provides a global enable (arbiter on/off) and a saturating accepted-word counter for debug/verification.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, FIFO data width in bits.
- MAX_BURST, 8, maximum words accepted per grant (1..256).
- CNTW, 16, width of the accepted-word counter.

Ports:
- CLK  in  1  write-domain clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- EN  in  1  arbitration enable; 0 blocks new grants.
- REQ  in  NREQ  per-requester request; REQ[i]=1 means REQ_DATA slice i holds a valid word.
- REQ_DATA  in  NREQ*WIDTH  packed data; slice i is bits [i*WIDTH +: WIDTH].
- ACK  out  NREQ  one-hot; word from requester i accepted this cycle (combinational).
- GNT  out  NREQ  one-hot registered grant; all-zero when idle.
- FIFO_FULL  in  1  FULL flag from the FIFO.
- FIFO_WE  out  1  FIFO write enable (combinational).
- FIFO_DATA  out  WIDTH  FIFO write data: granted slice, or zero when FIFO_WE=0.
- BUSY  out  1  registered; 1 while in BURST.
- WORD_CNT  out  CNTW  registered count of accepted words; saturates at all-ones.

Behaviour:
- Reset (RESET_N=0 at a clock edge):
  - GNT=0, BUSY=0, WORD_CNT=0, state=IDLE, burst_cnt=0, rr_ptr=NREQ-1 (requester 0 wins first).
  - ACK=0 and FIFO_WE=0 while in reset.
  - A burst in progress is abandoned with no further writes.
- States: IDLE, BURST.
- IDLE:
  - If EN=1 and REQ is non-zero, select the first i with REQ[i]=1, searching from rr_ptr+1 with modulo-NREQ wrap.
  - Next cycle: GNT=onehot(i), BUSY=1, state=BURST, burst_cnt=0.
  - No ACK or FIFO_WE is ever issued in IDLE.
- BURST, granted requester g:
  - accept = REQ[g] & ~FIFO_FULL. ACK[g]=accept, FIFO_WE=accept, FIFO_DATA=slice g. Zero latency: data is written in the same cycle ACK is asserted.
  - Each accept increments burst_cnt and WORD_CNT (saturating).
  - FIFO_FULL=1: no accept, GNT held, burst_cnt unchanged. There is no timeout.
  - Exit to IDLE on the next edge when either:
    - accept occurs and burst_cnt==MAX_BURST-1, or
    - REQ[g]=0 (requester withdrew).
  - On exit: rr_ptr<=g, GNT<=0, BUSY<=0.
  - Exactly one IDLE bubble cycle occurs between consecutive bursts.
- EN:
  - Sampled only in IDLE.
  - EN falling during BURST does not truncate the burst.
  - EN=0 in IDLE holds IDLE with GNT=0.
- Requests from non-granted requesters are ignored; they keep REQ/data stable until ACKed.
- FIFO_FULL rising in the same cycle as the final word: that word is not accepted and the burst stays open.
- Widths:
  - burst_cnt is clog2(MAX_BURST) bits, minimum 1.
  - rr_ptr is clog2(NREQ) bits; wrap is explicit modulo, so non-power-of-two NREQ is legal.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding (IDLE=1'b0, BURST=1'b1);
  - a clog2 function;
  - default constants for NREQ/WIDTH/MAX_BURST.
- One sub-module: rr_pick (combinational round-robin selector; inputs REQ and rr_ptr, outputs a one-hot winner and its index).

Test Plan:
- Reset then REQ=4'b0001, EN=1, FULL=0, data 0x00A0..: GNT=0001 at cycle 2, then 8 ACKs/WEs with data 0x00A0..0x00A7, then GNT=0 for one cycle; WORD_CNT=8.
- REQ=4'b1111 held, all FULL=0: grant order 0,1,2,3,0, each burst exactly 8 words with one bubble between; WORD_CNT=40 after five bursts.
- Requester 2 bursting, FULL=1 for cycles 3–6 of the burst: no WE during the stall, GNT stays 0100, and the burst still totals 8 words once FULL clears.
- Requester 1 drops REQ after 3 words: burst ends with 3 WEs, rr_ptr=1, and the next grant goes to requester 2 when REQ=0110.
- EN=0 with REQ=1111: GNT stays 0; EN dropped mid-burst: the current burst completes all 8 words, then no new grant.
- RESET_N=0 mid-burst after 5 words: next cycle GNT=0, WE=0, WORD_CNT=0; after release with REQ=1000, requester 3 is granted (rr_ptr reset to NREQ-1).
